// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data and full/empty flags
// Storage is a flat register array indexed by absolute slot; pointers wrap at FIFO_DEPTH-1.
module sync_fifo #(
  parameter int FIFO_WIDTH = 36,
  parameter int FIFO_DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  clr_in,
  input  logic                  we_in,
  input  logic                  rd_in,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic                  empty_out,
  output logic                  full_out,
  output logic [FIFO_WIDTH-1:0] data_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] fifo_block_r [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  do_wr, do_rd;

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == CNT_W'(FIFO_DEPTH));
  assign data_out  = data_q;

  always_comb begin
    do_rd    = rd_in && !empty_out;
    // A write while full is accepted only when a read frees the slot on the same edge.
    do_wr    = we_in && (!full_out || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    if (do_wr) begin
      wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PTR_W'(1);
      data_d   = fifo_block_r[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr_in) begin
    if (clr_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_block_r[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      if (do_wr) begin
        fifo_block_r[wr_ptr_q] <= data_in;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;

  localparam int W = 36;
  localparam int D = 10;

  logic         clk = 1'b0;
  logic         clr_in;
  logic         we_in;
  logic         rd_in;
  logic [W-1:0] data_in;
  logic         empty_out;
  logic         full_out;
  logic [W-1:0] data_out;

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .clr_in   (clr_in),
    .we_in    (we_in),
    .rd_in    (rd_in),
    .data_in  (data_in),
    .empty_out(empty_out),
    .full_out (full_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] sb_q [$];
  logic [W-1:0] mem [0:D-1];
  logic [W-1:0] exp_dout;
  int           m_cnt;
  int           m_wr;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    sb_q.delete();
    for (int i = 0; i < D; i++) mem[i] = '0;
    exp_dout = '0;
    m_cnt    = 0;
    m_wr     = 0;
  endtask

  task automatic check_storage(input string tag);
    for (int i = 0; i < D; i++) check_eq(tag, dut.fifo_block_r[i], mem[i]);
  endtask

  // One clock with the given requests; model decides acceptance from its own state.
  task automatic step(input logic we, input logic rd, input logic [W-1:0] d);
    bit acc_r, acc_w;
    we_in   = we;
    rd_in   = rd;
    data_in = d;
    acc_r = rd && (m_cnt > 0);
    acc_w = we && ((m_cnt < D) || acc_r);
    if (acc_r) exp_dout = sb_q.pop_front();
    if (acc_w) begin
      sb_q.push_back(d);
      mem[m_wr] = d;
      m_wr = (m_wr == D - 1) ? 0 : m_wr + 1;
    end
    m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
    @(posedge clk);
    #1;
    check_eq("data_out", data_out, exp_dout);
    check_eq("empty", W'(empty_out), W'(m_cnt == 0));
    check_eq("full", W'(full_out), W'(m_cnt == D));
  endtask

  initial begin
    clr_in  = 1'b1;
    we_in   = 1'b0;
    rd_in   = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clr_in = 1'b0;
    check_storage("reset_mem");
    check_eq("reset_empty", W'(empty_out), W'(1));
    check_eq("reset_full", W'(full_out), W'(0));
    check_eq("reset_dout", data_out, '0);

    for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i));
    check_storage("fill_mem");
    check_eq("fill_slot9", dut.fifo_block_r[9], W'(9));

    for (int i = 0; i < D; i++) step(1'b0, 1'b1, '0);
    check_eq("drain_last", data_out, W'(9));

    step(1'b1, 1'b1, W'(36'hBEEF));
    check_eq("sim_empty_slot0", dut.fifo_block_r[0], W'(36'hBEEF));
    check_eq("sim_empty_dout", data_out, W'(9));
    check_eq("sim_empty_count", W'(dut.count_q), W'(1));

    for (int i = 10; i <= 18; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b0, W'(36'hBEEF));
    check_storage("overflow_mem");
    check_eq("overflow_full", W'(full_out), W'(1));

    step(1'b1, 1'b1, W'(36'h1234));
    check_eq("sim_full_dout", data_out, W'(36'hBEEF));
    check_eq("sim_full_slot0", dut.fifo_block_r[0], W'(36'h1234));
    check_storage("sim_full_mem");

    while (m_cnt > 0) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), {4'($urandom), $urandom});
    end
    check_storage("random_mem");

    #2;
    clr_in = 1'b1;
    #1;
    model_reset();
    check_eq("async_empty", W'(empty_out), W'(1));
    check_eq("async_full", W'(full_out), W'(0));
    check_eq("async_dout", data_out, '0);
    check_storage("async_mem");
    @(posedge clk);
    #1;
    clr_in = 1'b0;
    step(1'b1, 1'b0, W'(36'hA5A5A5A5A));
    step(1'b0, 1'b1, '0);
    check_eq("post_reset_dout", data_out, W'(36'hA5A5A5A5A));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterised first-in-first-out buffer with a registered read-data port and full/empty status flags. It decouples producer and consumer logic in the VGA controller datapath, such as pixel/line data staging, where both sides run on the same clock. Storage is a flat register array, so contents are visible hierarchically to benches.

## Interface
- FIFO_WIDTH, 36: data word width in bits.
- FIFO_DEPTH, 10: number of entries; any value ≥ 2, not required to be a power of two.

- clk  in  1  system clock; all state updates on its rising edge.
- clr_in  in  1  asynchronous, active-high reset (clear).
- we_in  in  1  write request.
- rd_in  in  1  read request.
- data_in  in  FIFO_WIDTH  write data.
- empty_out  out  1  high when occupancy = 0.
- full_out  out  1  high when occupancy = FIFO_DEPTH.
- data_out  out  FIFO_WIDTH  registered read data.

## Operation
- Storage: register array `fifo_block_r[0:FIFO_DEPTH-1]`, each FIFO_WIDTH bits, indexed by absolute slot. Entry 0 is the first slot written after reset.
- State: write pointer, read pointer (0..FIFO_DEPTH-1), occupancy count (0..FIFO_DEPTH, width $clog2(FIFO_DEPTH+1)).
- Pointers wrap explicitly from FIFO_DEPTH-1 to 0. Modulo-2^n wrap is not permitted.
- Reset (clr_in = 1, asynchronous): all storage entries = 0, both pointers = 0, count = 0, data_out = 0.
- Per rising edge, with clr_in = 0:
  - we_in=1, rd_in=0, not full: fifo_block_r[wr_ptr] ← data_in; wr_ptr advances; count +1.
  - we_in=1, rd_in=0, full: write ignored; no state change.
  - rd_in=1, we_in=0, not empty: data_out ← fifo_block_r[rd_ptr]; rd_ptr advances; count −1.
  - rd_in=1, we_in=0, empty: read ignored; data_out holds.
  - we_in=1, rd_in=1, empty: treated as a write only; data_out holds; count becomes 1.
  - we_in=1, rd_in=1, not empty (including full):
    - data_out ← fifo_block_r[rd_ptr].
    - fifo_block_r[wr_ptr] ← data_in.
    - Both pointers advance; count unchanged.
    - When full, the read uses the old slot contents, so the oldest word is read before it is overwritten.
  - Neither request: no change; data_out holds.
- Reading does not clear storage entries; stale data remains until overwritten.
- empty_out = (count == 0), full_out = (count == FIFO_DEPTH): combinational decode of the registered count, with no other logic.

## Timing
- Write latency: a word written at edge N is readable by a read request sampled at edge N+1.
- Read latency: data_out updates on the same rising edge that samples rd_in. It is valid after that edge and stable for the whole following cycle.
- Flags reflect the post-edge count within the same cycle; no extra flag latency.
- Reset mid-operation: all state clears immediately, independent of clk. Outputs after reset: empty_out=1, full_out=0, data_out=0.
- No handshake beyond we_in/rd_in levels. Each cycle a request is high counts as one request; callers must observe the flags.

## Test plan
- Reset: hold clr_in=1 for 2 cycles, then release -> all fifo_block_r entries 0, empty_out=1, full_out=0, data_out=0.
- Fill: we_in=1 with data_in=0..9 over 10 cycles (DEPTH=10) -> fifo_block_r[i]=i; empty_out=0 after the first edge; full_out=1 after the 10th edge.
- Drain: rd_in=1, we_in=0 for 10 cycles -> data_out=0,1,…,9 on successive edges; full_out=0 after the first read; empty_out=1 after the 10th.
- Simultaneous on empty: we_in=rd_in=1, data_in=0xBEEF -> slot 0 (wrapped write pointer) = 0xBEEF, count=1, data_out unchanged, empty_out=0.
- Overflow: write 9 more words (10..18) to reach full, then we_in=1, rd_in=0, data_in=0xBEEF -> storage unchanged, full_out=1, empty_out=0.
- Simultaneous on full: we_in=rd_in=1, data_in=0x1234 -> data_out=oldest word (0xBEEF); 0x1234 stored in that slot; full_out stays 1.
